// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame constants
// and the even-parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic        START_BIT      = 1'b0;
    localparam logic        STOP_BIT       = 1'b1;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// reset to RST_VAL so the output starts in the input's idle level.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, mid-bit
// sampling from an internal clocks-per-bit counter.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_e                state, state_nxt;
    logic                       rx_s;
    logic [CNT_W-1:0]           cnt;
    logic [2:0]                 bit_idx;
    logic [UART_DATA_BITS-1:0]  shift;
    logic                       par_bit;
    logic                       cnt_clr, shift_en, par_en, frame_done;

    uart_rx_sync #(
        .RST_VAL(STOP_BIT)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (rx_s == START_BIT) state_nxt = START;
            end
            START: begin
                // Re-check at mid start bit rejects short idle-line glitches.
                if (cnt == MID_CNT) begin
                    cnt_clr   = 1'b1;
                    state_nxt = (rx_s == START_BIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT) state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (cnt == LAST_CNT) begin
                    cnt_clr   = 1'b1;
                    par_en    = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_clr    = 1'b1;
                    frame_done = 1'b1;
                    state_nxt  = (rx_s == STOP_BIT) ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // A held-low line must go idle before another start is honoured.
                cnt_clr = 1'b1;
                if (rx_s == STOP_BIT) state_nxt = IDLE;
            end
            default: begin
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            cnt   <= cnt_clr ? '0 : cnt + CNT_W'(1);

            if (state != DATA) bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 3'd1;

            if (shift_en) shift[bit_idx] <= rx_s;
            if (par_en)   par_bit        <= rx_s;

            if (frame_done) begin
                valid      <= 1'b1;
                data_out   <= shift;
                parity_err <= (par_bit != even_parity(shift));
                frame_err  <= (rx_s != STOP_BIT);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frames, a negedge
// monitor pops and checks them whenever valid is seen.
module tb_uart_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned LAT = 2 + CPB / 2 + 10 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] data_out;
    logic       valid, parity_err, frame_err, busy;

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        fe;
        int unsigned exp_cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got data_out=%0h expected no valid (cycle %0d)", data_out, cyc);
            end else begin
                e = sb.pop_front();
                check("data_out", int'(data_out), int'(e.d));
                check("parity_err", int'(parity_err), int'(e.pe));
                check("frame_err", int'(frame_err), int'(e.fe));
                total++;
                if (cyc + 1 < e.exp_cyc || cyc > e.exp_cyc + 1) begin
                    bad++;
                    $display("FAIL latency: got cycle %0d expected %0d +-1", cyc, e.exp_cyc);
                end
            end
        end
    end

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    // Entered and left at posedge+1 so back-to-back calls have zero gap.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic exp_pe, input logic exp_fe);
        logic [10:0] bits;
        exp_t        e;
        bits      = mk_frame(d, par, stop);
        e.d       = d;
        e.pe      = exp_pe;
        e.fe      = exp_fe;
        e.exp_cyc = cyc + LAT;
        sb.push_back(e);
        for (int i = 0; i < 11; i++) begin
            rx_in = bits[i];
            wait_cycles(CPB);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, int'(data_out), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_parity_err"}, int'(parity_err), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic drain(input int unsigned limit);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            wait_cycles(1);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d frames outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [10:0] bits;

        wait_cycles(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_cycles(4);

        // Clean frame, correct parity bit, odd-weight byte, wrong parity bit.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_cycles(CPB);
        check("idle_busy_after_A5", int'(busy), 0);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_cycles(CPB);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_cycles(2 * CPB);
        drain(LAT);

        // 5-cycle glitch: starts a START check, then rejected.
        rx_in = 1'b0;
        wait_cycles(4);
        check("glitch_busy_high", int'(busy), 1);
        wait_cycles(1);
        rx_in = 1'b1;
        wait_cycles(CPB / 2 + 3 - 5);
        check("glitch_busy_low", int'(busy), 0);
        wait_cycles(2 * CPB);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_cycles(CPB);
        drain(LAT);

        // Stop bit low, then a long break: one frame error, no 0x00 frames.
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_cycles(20 * CPB);
        check("break_busy", int'(busy), 1);
        wait_cycles(20 * CPB - CPB);
        rx_in = 1'b1;
        wait_cycles(CPB);
        check("break_released_busy", int'(busy), 0);
        drain(4);
        wait_cycles(2 * CPB);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_cycles(CPB);
        drain(LAT);

        // Reset in the middle of data bit 4 of 0x81.
        bits = mk_frame(8'h81, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            rx_in = bits[i];
            wait_cycles(CPB);
        end
        rx_in = bits[5];
        wait_cycles(CPB / 2);
        rst   = 1'b1;
        rx_in = 1'b1;
        #1;
        check_reset_outputs("midframe_reset");
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2 * CPB);
        check("post_reset_busy", int'(busy), 0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_cycles(CPB);
        drain(LAT);

        wait_cycles(4 * CPB);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the downstream partner of the team's UART transmitter.
- Deserialises one asynchronous frame per character: start bit 0, 8 data bits LSB-first, even parity bit (XOR of the data bits), stop bit 1.
- Presents each byte with a one-cycle valid strobe and per-frame error flags to the consuming logic.
- Mid-bit sampling uses an internal clocks-per-bit counter; no external baud tick is needed.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range 4..65535.
- CNT_W, $clog2(CLKS_PER_BIT): bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rx_in  input  1  serial line, asynchronous to clk, idles high.
- data_out  output  8  last received byte; held until the next completed frame.
- valid  output  1  one-cycle pulse: a frame has completed and data_out/flags are updated.
- parity_err  output  1  qualified by valid: received parity != ^data_out.
- frame_err  output  1  qualified by valid: stop bit sampled as 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: data_out=0, valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE. Synchroniser flops reset to 1 (idle line).
- rx_in passes through a 2-flop synchroniser. All logic below uses the synchronised value rx_s.
- Counter cnt counts clk cycles within a bit. bit_idx (3 bits) indexes the data bits.
- IDLE:
  - rx_s==0 enters START with cnt=0.
- START:
  - At cnt==CLKS_PER_BIT/2-1, sample rx_s.
  - If 0: go to DATA, cnt=0, bit_idx=0.
  - If 1: false start; return to IDLE with no valid pulse.
- DATA:
  - At cnt==CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] (LSB first) and reset cnt.
  - After bit_idx==7 is sampled, go to PARITY.
- PARITY:
  - At cnt==CLKS_PER_BIT-1, capture par_bit and go to STOP.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rx_s.
  - On the next edge:
    - valid=1 for exactly one cycle.
    - data_out=shift.
    - parity_err=(par_bit != ^shift).
    - frame_err=(rx_s==0).
  - If the stop bit was 1: go to IDLE.
  - If the stop bit was 0: go to BREAK.
- BREAK:
  - Wait for rx_s==1, then go to IDLE.
  - Prevents a held-low line (break) from being decoded as back-to-back 0x00 frames.
- Latency:
  - The valid pulse occurs 2 (sync) + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1 cycles after the rx_in falling edge, ±1 cycle of synchroniser phase.
- Error flags:
  - parity_err and frame_err are meaningful only while valid=1.
  - They hold their value until the next valid. Consumers ignore them otherwise.
- Back-to-back frames:
  - A start edge arriving immediately after the stop-bit sample is accepted.
  - No idle gap is required beyond the stop bit.
- Glitches:
  - A low pulse shorter than CLKS_PER_BIT/2 cycles in IDLE is rejected by the START re-check.
  - Glitches within data bits are not filtered; single sample at mid-bit.
- Reset mid-frame:
  - Asynchronous return to IDLE. Outputs go to reset values immediately.
  - The partial byte is discarded and no valid is emitted.
  - The line must then be observed idle-high... no: the next falling edge starts a new frame. Mid-frame data low bits after reset may produce a garbage frame; reset is expected to be applied with the line idle.
- Odd CLKS_PER_BIT: the mid-point is floor(CLKS_PER_BIT/2)-1.

Decomposition:
- Package uart_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - UART_DATA_BITS=8.
  - frame bit constants START_BIT=0, STOP_BIT=1.
  - Shared with the transmitter.
- Sub-module uart_rx_sync: 2-flop synchroniser with parameterised reset value. Reused for other asynchronous inputs.

Test Plan:
- Byte 0xA5, parity 0, stop 1, CLKS_PER_BIT=16 -> one valid pulse, data_out=0xA5, parity_err=0, frame_err=0; busy=0 after.
- Byte 0x3C sent with wrong parity bit 1 -> valid, data_out=0x3C, parity_err=1, frame_err=0.
- Byte 0xFF, parity 0, stop bit driven 0, then line held low 40 bit times -> exactly one valid with frame_err=1, data_out=0xFF; no further valid until the line returns high and a new start arrives.
- 5-cycle low glitch on idle line -> no valid, busy returns to 0 within CLKS_PER_BIT/2+3 cycles.
- Back-to-back 0x00, 0x55, 0xAA with zero idle gap -> three valid pulses spaced 11*CLKS_PER_BIT cycles, correct data, no errors.
- rst asserted during DATA bit 4 of 0x81 -> outputs reset immediately, no valid. The following clean 0x81 frame is received correctly.
